// File: rtl/plab5_mcore_mem_sec_checker.sv
// Security checker between the memory arbiter and main memory: blocks low-domain
// accesses to one secure address window and answers them locally.
module plab5_mcore_mem_sec_checker #(
  parameter int                      p_opaque_nbits = 8,
  parameter int                      p_addr_nbits   = 32,
  parameter int                      p_data_nbits   = 32,
  parameter logic [p_addr_nbits-1:0] p_sec_base     = 'h0000_8000,
  parameter logic [p_addr_nbits-1:0] p_sec_bound    = 'h0000_FFFF,
  parameter int                      p_cnt_nbits    = 16,
  localparam int                     rqc            = 3 + p_opaque_nbits + p_addr_nbits + 2,
  localparam int                     rsc            = 3 + p_opaque_nbits + 2
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    req_val,
  output logic                    req_rdy,
  input  logic [rqc-1:0]          req_control,
  input  logic [p_data_nbits-1:0] req_data,
  input  logic                    req_domain,

  output logic                    mem_req_val,
  input  logic                    mem_req_rdy,
  output logic [rqc-1:0]          mem_req_control,
  output logic [p_data_nbits-1:0] mem_req_data,

  input  logic                    mem_resp_val,
  output logic                    mem_resp_rdy,
  input  logic [rsc-1:0]          mem_resp_control,
  input  logic [p_data_nbits-1:0] mem_resp_data,

  output logic                    resp_val,
  input  logic                    resp_rdy,
  output logic [rsc-1:0]          resp_control,
  output logic [p_data_nbits-1:0] resp_data,
  output logic                    resp_insecure,
  output logic                    resp_domain,

  output logic [p_cnt_nbits-1:0]  deny_count
);

  typedef enum logic [2:0] {
    IDLE,
    FWD,
    WAIT,
    RESP,
    DENY
  } state_t;

  state_t state;
  logic   domain_q;

  logic [p_addr_nbits-1:0]   in_addr;
  logic [2:0]                in_type;
  logic [p_opaque_nbits-1:0] in_opaque;
  logic [1:0]                in_len;
  logic                      in_viol;

  assign in_addr   = req_control[p_addr_nbits+1:2];
  assign in_type   = req_control[rqc-1 -: 3];
  assign in_opaque = req_control[rqc-4 -: p_opaque_nbits];
  assign in_len    = req_control[1:0];

  // Window bounds are inclusive; the secure domain is never blocked.
  assign in_viol = !req_domain && (in_addr >= p_sec_base) && (in_addr <= p_sec_bound);

  // All val/rdy outputs are registered and reset to 0, so req_rdy first rises
  // on the first clock edge after reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      domain_q        <= 1'b0;
      req_rdy         <= 1'b0;
      mem_req_val     <= 1'b0;
      mem_req_control <= '0;
      mem_req_data    <= '0;
      mem_resp_rdy    <= 1'b0;
      resp_val        <= 1'b0;
      resp_control    <= '0;
      resp_data       <= '0;
      resp_insecure   <= 1'b0;
      resp_domain     <= 1'b0;
      deny_count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_rdy <= 1'b1;
          if (req_val && req_rdy) begin
            req_rdy         <= 1'b0;
            mem_req_control <= req_control;
            mem_req_data    <= req_data;
            domain_q        <= req_domain;
            if (in_viol) begin
              state         <= DENY;
              resp_val      <= 1'b1;
              resp_control  <= {in_type, in_opaque, in_len};
              resp_data     <= '0;
              resp_insecure <= 1'b1;
              resp_domain   <= 1'b0;
            end else begin
              state       <= FWD;
              mem_req_val <= 1'b1;
            end
          end
        end

        FWD: begin
          if (mem_req_rdy) begin
            mem_req_val  <= 1'b0;
            mem_resp_rdy <= 1'b1;
            state        <= WAIT;
          end
        end

        WAIT: begin
          if (mem_resp_val) begin
            mem_resp_rdy  <= 1'b0;
            resp_val      <= 1'b1;
            resp_control  <= mem_resp_control;
            resp_data     <= mem_resp_data;
            resp_insecure <= 1'b0;
            resp_domain   <= domain_q;
            state         <= RESP;
          end
        end

        RESP, DENY: begin
          if (resp_rdy) begin
            resp_val      <= 1'b0;
            resp_control  <= '0;
            resp_data     <= '0;
            resp_insecure <= 1'b0;
            resp_domain   <= 1'b0;
            req_rdy       <= 1'b1;
            state         <= IDLE;
            if ((state == DENY) && (deny_count != '1))
              deny_count <= deny_count + p_cnt_nbits'(1);
          end
        end

        default: begin
          state         <= IDLE;
          req_rdy       <= 1'b0;
          mem_req_val   <= 1'b0;
          mem_resp_rdy  <= 1'b0;
          resp_val      <= 1'b0;
          resp_control  <= '0;
          resp_data     <= '0;
          resp_insecure <= 1'b0;
          resp_domain   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_plab5_mcore_mem_sec_checker.sv
// Bench for plab5_mcore_mem_sec_checker: the bench plays arbiter and memory and
// predicts every response from the window rule and a reference memory array.
module tb_plab5_mcore_mem_sec_checker;

  localparam int RQC = 3 + 8 + 32 + 2;
  localparam int RSC = 3 + 8 + 2;
  localparam logic [31:0] SEC_BASE  = 32'h0000_8000;
  localparam logic [31:0] SEC_BOUND = 32'h0000_FFFF;
  localparam logic [2:0]  RD = 3'd0;
  localparam logic [2:0]  WR = 3'd1;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_val, req_rdy;
  logic [RQC-1:0]   req_control;
  logic [31:0]      req_data;
  logic             req_domain;
  logic             mem_req_val, mem_req_rdy;
  logic [RQC-1:0]   mem_req_control;
  logic [31:0]      mem_req_data;
  logic             mem_resp_val, mem_resp_rdy;
  logic [RSC-1:0]   mem_resp_control;
  logic [31:0]      mem_resp_data;
  logic             resp_val, resp_rdy;
  logic [RSC-1:0]   resp_control;
  logic [31:0]      resp_data;
  logic             resp_insecure, resp_domain;
  logic [3:0]       deny_count;

  int total = 0;
  int bad   = 0;
  int ref_deny = 0;

  logic [31:0] stub_mem [logic [31:0]];
  logic [31:0] ref_mem  [logic [31:0]];

  plab5_mcore_mem_sec_checker #(.p_cnt_nbits(4)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_control(req_control),
    .req_data(req_data), .req_domain(req_domain),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
    .mem_req_control(mem_req_control), .mem_req_data(mem_req_data),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy),
    .mem_resp_control(mem_resp_control), .mem_resp_data(mem_resp_data),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_control(resp_control),
    .resp_data(resp_data), .resp_insecure(resp_insecure), .resp_domain(resp_domain),
    .deny_count(deny_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] stub_rd(input logic [31:0] a);
    return stub_mem.exists(a) ? stub_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    stub_mem[a] = d;
    ref_mem[a]  = d;
  endtask

  // One full transaction; the bench answers as memory using what the DUT forwarded.
  task automatic run_txn(input logic [2:0] typ, input logic [7:0] opq, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic dom,
                         input int req_stall, input int resp_stall, input int mem_lat);
    logic [RQC-1:0] ctl, got_ctl;
    logic [RSC-1:0] exp_rctl;
    logic [31:0]    exp_data, got_data, rdata, faddr;
    logic [3:0]     exp_deny;
    logic           viol;
    int             n;
    ctl      = {typ, opq, addr, 2'b00};
    exp_rctl = {typ, opq, 2'b00};
    viol     = (dom == 1'b0) && (addr >= SEC_BASE) && (addr <= SEC_BOUND);
    got_ctl  = '0;
    got_data = '0;
    n = 0;
    while (req_rdy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (req_rdy !== 1'b1) begin
      bad++;
      $display("FAIL req_rdy_wait got=%b exp=1", req_rdy);
      return;
    end
    req_val = 1'b1; req_control = ctl; req_data = wdata; req_domain = dom;
    @(negedge clk);
    req_val = 1'b0; req_control = '0; req_data = '0; req_domain = 1'b0;
    total++;
    if (req_rdy !== 1'b0 || mem_req_val !== !viol || resp_val !== viol) begin
      bad++;
      $display("FAIL accept_latency got rdy=%b mreq=%b resp=%b exp rdy=0 mreq=%b resp=%b",
               req_rdy, mem_req_val, resp_val, !viol, viol);
    end
    if (viol) begin
      for (int i = 0; i <= resp_stall; i++) begin
        total++;
        if (resp_val !== 1'b1 || resp_control !== exp_rctl || resp_data !== 32'h0 ||
            resp_insecure !== 1'b1 || resp_domain !== 1'b0 || mem_req_val !== 1'b0 || req_rdy !== 1'b0) begin
          bad++;
          $display("FAIL deny_resp got val=%b ctl=%h data=%h ins=%b dom=%b mreq=%b rdy=%b exp val=1 ctl=%h data=0 ins=1 dom=0 mreq=0 rdy=0",
                   resp_val, resp_control, resp_data, resp_insecure, resp_domain, mem_req_val, req_rdy, exp_rctl);
        end
        if (i == resp_stall) resp_rdy = 1'b1;
        @(negedge clk);
      end
      resp_rdy = 1'b0;
      ref_deny++;
    end else begin
      for (int i = 0; i <= req_stall; i++) begin
        total++;
        if (mem_req_val !== 1'b1 || mem_req_control !== ctl || mem_req_data !== wdata ||
            req_rdy !== 1'b0 || resp_val !== 1'b0 || mem_resp_rdy !== 1'b0) begin
          bad++;
          $display("FAIL fwd_req got val=%b ctl=%h data=%h rdy=%b resp=%b mrr=%b exp val=1 ctl=%h data=%h rdy=0 resp=0 mrr=0",
                   mem_req_val, mem_req_control, mem_req_data, req_rdy, resp_val, mem_resp_rdy, ctl, wdata);
        end
        got_ctl  = mem_req_control;
        got_data = mem_req_data;
        if (i == req_stall) mem_req_rdy = 1'b1;
        @(negedge clk);
      end
      mem_req_rdy = 1'b0;
      faddr = got_ctl[33:2];
      if (got_ctl[44:42] == WR) begin
        stub_mem[faddr] = got_data;
        rdata = 32'h0;
      end else begin
        rdata = stub_rd(faddr);
      end
      if (typ == WR) begin
        ref_mem[addr] = wdata;
        exp_data = 32'h0;
      end else begin
        exp_data = ref_rd(addr);
      end
      for (int k = 0; k <= mem_lat; k++) begin
        total++;
        if (mem_resp_rdy !== 1'b1 || mem_req_val !== 1'b0 || resp_val !== 1'b0) begin
          bad++;
          $display("FAIL wait_state got mrr=%b mreq=%b resp=%b exp mrr=1 mreq=0 resp=0",
                   mem_resp_rdy, mem_req_val, resp_val);
        end
        if (k == mem_lat) begin
          mem_resp_val     = 1'b1;
          mem_resp_control = {got_ctl[44:42], got_ctl[41:34], got_ctl[1:0]};
          mem_resp_data    = rdata;
        end
        @(negedge clk);
      end
      mem_resp_val = 1'b0; mem_resp_control = '0; mem_resp_data = '0;
      for (int i = 0; i <= resp_stall; i++) begin
        total++;
        if (resp_val !== 1'b1 || resp_control !== exp_rctl || resp_data !== exp_data ||
            resp_insecure !== 1'b0 || resp_domain !== dom || mem_resp_rdy !== 1'b0 || req_rdy !== 1'b0) begin
          bad++;
          $display("FAIL mem_resp got val=%b ctl=%h data=%h ins=%b dom=%b mrr=%b rdy=%b exp val=1 ctl=%h data=%h ins=0 dom=%b mrr=0 rdy=0",
                   resp_val, resp_control, resp_data, resp_insecure, resp_domain, mem_resp_rdy, req_rdy,
                   exp_rctl, exp_data, dom);
        end
        if (i == resp_stall) resp_rdy = 1'b1;
        @(negedge clk);
      end
      resp_rdy = 1'b0;
    end
    exp_deny = (ref_deny > 15) ? 4'hF : 4'(ref_deny);
    total++;
    if (resp_val !== 1'b0 || resp_data !== 32'h0 || resp_control !== '0 || resp_insecure !== 1'b0 ||
        req_rdy !== 1'b1 || deny_count !== exp_deny) begin
      bad++;
      $display("FAIL txn_done got val=%b data=%h ctl=%h ins=%b rdy=%b cnt=%0d exp val=0 data=0 ctl=0 ins=0 rdy=1 cnt=%0d",
               resp_val, resp_data, resp_control, resp_insecure, req_rdy, deny_count, exp_deny);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (req_rdy !== 1'b0 || mem_req_val !== 1'b0 || mem_resp_rdy !== 1'b0 || resp_val !== 1'b0 ||
        resp_data !== 32'h0 || deny_count !== 4'h0) begin
      bad++;
      $display("FAIL reset_state got rdy=%b mreq=%b mrr=%b resp=%b data=%h cnt=%0d exp all 0",
               req_rdy, mem_req_val, mem_resp_rdy, resp_val, resp_data, deny_count);
    end
    reset = 1'b1;
    ref_deny = 0;
    @(negedge clk);
  endtask

  task automatic test_allowed_read;
    preload(32'h1000, 32'hCAFE_BABE);
    run_txn(RD, 8'h5A, 32'h1000, 32'h0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_blocked_read;
    run_txn(RD, 8'h21, 32'h8000, 32'h0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_blocked_write_secure_read;
    preload(32'h9000, 32'h5555_AAAA);
    run_txn(WR, 8'h31, 32'h9000, 32'h1234, 1'b0, 0, 1, 0);
    run_txn(RD, 8'h32, 32'h9000, 32'h0, 1'b1, 0, 0, 1);
  endtask

  task automatic test_boundary;
    logic [31:0] addrs [6];
    addrs = '{32'h7FFC, 32'h7FFF, 32'h8000, 32'hFFFF, 32'h1_0000, 32'h1_0004};
    foreach (addrs[i]) run_txn(RD, 8'(i), addrs[i], 32'h0, 1'b0, 0, 0, 0);
    run_txn(WR, 8'h77, 32'hFFFF, 32'hDEAD_0001, 1'b1, 0, 0, 0);
    run_txn(RD, 8'h78, 32'hFFFF, 32'h0, 1'b1, 0, 0, 0);
  endtask

  task automatic test_back_to_back;
    run_txn(WR, 8'h41, 32'h2000, 32'hA5A5_0001, 1'b0, 5, 5, 2);
    run_txn(RD, 8'h42, 32'hC000, 32'h0, 1'b0, 0, 5, 0);
    run_txn(RD, 8'h43, 32'h2000, 32'h0, 1'b0, 5, 5, 3);
  endtask

  task automatic test_random;
    logic [31:0] a;
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 2))
        0:       a = 32'($urandom_range(32'h7FF0, 32'h8010));
        1:       a = 32'($urandom_range(32'hFFF0, 32'h1_0010));
        default: a = 32'($urandom_range(0, 32'h1_FFFF));
      endcase
      run_txn(($urandom_range(0, 1) == 1) ? WR : RD, 8'($urandom), a, 32'($urandom),
              1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_mid_wait;
    int n;
    n = 0;
    while (req_rdy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    req_val = 1'b1; req_control = {RD, 8'h99, 32'h2000, 2'b00}; req_data = '0; req_domain = 1'b1;
    @(negedge clk);
    req_val = 1'b0; req_control = '0; req_domain = 1'b0;
    mem_req_rdy = 1'b1;
    @(negedge clk);
    mem_req_rdy = 1'b0;
    total++;
    if (mem_resp_rdy !== 1'b1) begin
      bad++;
      $display("FAIL reach_wait got mrr=%b exp=1", mem_resp_rdy);
    end
    reset = 1'b0;
    #1;
    total++;
    if (req_rdy !== 1'b0 || mem_req_val !== 1'b0 || mem_resp_rdy !== 1'b0 || resp_val !== 1'b0 ||
        deny_count !== 4'h0) begin
      bad++;
      $display("FAIL reset_mid_wait got rdy=%b mreq=%b mrr=%b resp=%b cnt=%0d exp all 0",
               req_rdy, mem_req_val, mem_resp_rdy, resp_val, deny_count);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    ref_deny = 0;
    @(negedge clk);
    run_txn(RD, 8'h9A, 32'h2000, 32'h0, 1'b1, 0, 0, 0);
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 17; i++)
      run_txn(RD, 8'(i), 32'h8000 + 32'(i * 4), 32'h0, 1'b0, 0, 0, 0);
  endtask

  initial begin
    req_val = 1'b0; req_control = '0; req_data = '0; req_domain = 1'b0;
    mem_req_rdy = 1'b0; mem_resp_val = 1'b0; mem_resp_control = '0; mem_resp_data = '0;
    resp_rdy = 1'b0;
    reset = 1'b0;
    test_reset();
    test_allowed_read();
    test_blocked_read();
    test_blocked_write_secure_read();
    test_boundary();
    test_back_to_back();
    test_random();
    test_reset_mid_wait();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
